// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter with a byte FIFO and a status/control register block
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFF200100,
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReadEnable,
    input  logic        iWriteEnable,
    input  logic [3:0]  iByteEnable,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic [31:0] oReadData,
    output logic        oTX,
    output logic        oBusy
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

    logic [7:0]    fifo [FIFO_DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [AW:0]   count;
    logic          overflow, enable, tx;
    txState_t      state, nextState;
    logic [15:0]   baud, nextBaud;
    logic [2:0]    bitIdx, nextBitIdx;
    logic [7:0]    shift, nextShift;
    logic          hit, wrData, wrStatus, wrCtrl, flush, pop, push, full, empty;
    logic [6:0]    count7;
    logic          unusedBits;

    assign hit      = iAddress[31:4] == BASE_ADDR[31:4];
    assign wrData   = iWriteEnable && hit && iAddress[3:2] == 2'd0 && iByteEnable[0];
    assign wrStatus = iWriteEnable && hit && iAddress[3:2] == 2'd1 && iByteEnable[0];
    assign wrCtrl   = iWriteEnable && hit && iAddress[3:2] == 2'd2 && iByteEnable[0];
    assign flush    = wrCtrl && iWriteData[1];
    assign full     = count == DEPTH;
    assign empty    = count == '0;
    assign pop      = state == IDLE && enable && !empty;
    assign push     = wrData && !flush && (!full || pop);
    assign count7   = 7'(count);
    assign oBusy    = state != IDLE;
    assign oTX      = tx;
    assign unusedBits = ^{iAddress[1:0], iWriteData[31:8], iByteEnable[3:1]};

    assign oReadData = !(iReadEnable && hit) ? '0 :
                       iAddress[3:2] == 2'd1 ? {17'b0, count7, 4'b0, overflow, oBusy, empty, full} :
                       iAddress[3:2] == 2'd2 ? {31'b0, enable} : '0;

    always_ff @(posedge iCLK)
        if (push)
            fifo[wrPtr] <= iWriteData[7:0];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            enable   <= 1'b1;
            state    <= IDLE;
            baud     <= '0;
            bitIdx   <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            if (flush) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                if (pop)  rdPtr <= rdPtr + AW'(1);
                if (push) wrPtr <= wrPtr + AW'(1);
                count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            end
            // a dropped push (full, no same-cycle pop) wins over a same-cycle clear
            overflow <= (wrData && !flush && !push) || (overflow && !(wrStatus && iWriteData[3]));
            if (wrCtrl) enable <= iWriteData[0];
            state  <= nextState;
            baud   <= nextBaud;
            bitIdx <= nextBitIdx;
            shift  <= nextShift;
            tx     <= nextState == START ? 1'b0 : nextState == DATA ? nextShift[0] : 1'b1;
        end
    end

    always_comb begin
        nextState  = state;
        nextBaud   = baud;
        nextBitIdx = bitIdx;
        nextShift  = shift;
        if (state == IDLE) begin
            if (pop) begin
                nextState = START;
                nextBaud  = RELOAD;
                nextShift = fifo[rdPtr];
            end
        end else if (baud != 16'd0) begin
            nextBaud = baud - 16'd1;
        end else begin
            nextBaud   = RELOAD;
            nextState  = state == START ? DATA : state == STOP ? IDLE : bitIdx == 3'd7 ? STOP : DATA;
            nextBitIdx = state == DATA ? bitIdx + 3'd1 : 3'd0;
            nextShift  = state == DATA ? shift >> 1 : shift;
        end
    end
endmodule
